seq_detect_param: RTL

Parametrised serial bit-pattern detector. It is the next generation of the fixed single-pattern `my_fsm` detector. The block samples one serial bit per qualified clock and compares the most recent `PATTERN_W` bits against a runtime-loadable pattern. It raises a registered one-cycle `out` pulse on each match and keeps a saturating match counter. Overlapping and non-overlapping detection modes are both supported. It sits between a serial input stage and control/status logic.

---
 rtl/seq_detect_param_if.sv | 29 ++
 rtl/seq_detect_param.sv | 84 ++++++++
 2 files changed

// File: rtl/seq_detect_param_if.sv
// Serial detector bus: sample/config inputs toward the detector,
// match pulse and counter back out.
interface seq_detect_param_if #(
  parameter int PATTERN_W = 4,
  parameter int COUNT_W   = 8
);
  logic                 in_valid;
  logic                 in;
  logic                 cfg_load;
  logic [PATTERN_W-1:0] cfg_pattern;
  logic                 cfg_overlap;
  logic                 count_clr;
  logic                 out;
  logic [COUNT_W-1:0]   match_count;

  modport master (
    output in_valid, in, cfg_load,
    output cfg_pattern, cfg_overlap,
    output count_clr,
    input  out, match_count
  );

  modport slave (
    input  in_valid, in, cfg_load,
    input  cfg_pattern, cfg_overlap,
    input  count_clr,
    output out, match_count
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with loadable pattern,
// overlap select and saturating match counter.
module seq_detect_param #(
  parameter int          PATTERN_W     = 4,
  parameter int          COUNT_W       = 8,
  parameter logic [31:0] RESET_PATTERN = 32'b1000
) (
  input logic clock,
  input logic reset,
  seq_detect_param_if.slave bus
);
  localparam int FW = $clog2(PATTERN_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_W);
  localparam logic [FW-1:0] NEAR = FW'(PATTERN_W - 1);

  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic                 ovl_q, ovl_d;
  logic [PATTERN_W-2:0] hist_q, hist_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic                 out_q, out_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;

  logic [PATTERN_W-1:0] window;
  logic                 accept;
  logic                 match;

  assign window = {hist_q, bus.in};
  assign accept = bus.in_valid & ~bus.cfg_load;
  // fill guards against stale history bits aliasing the pattern
  assign match  = accept & (fill_q >= NEAR)
                & (window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    if (bus.cfg_load) begin
      pat_d  = bus.cfg_pattern;
      ovl_d  = bus.cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.in_valid) begin
      hist_d = window[PATTERN_W-2:0];
      if (fill_q != FULL)
        fill_d = fill_q + FW'(1);
      if (match) begin
        out_d = 1'b1;
        if (!ovl_q)
          fill_d = '0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.count_clr)
      cnt_d = '0;
    else if (match && (cnt_q != {COUNT_W{1'b1}}))
      cnt_d = cnt_q + COUNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q  <= RESET_PATTERN[PATTERN_W-1:0];
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.match_count = cnt_q;
endmodule
